// File: rtl/code_axi_pkg.sv
// rtl/code_axi_pkg.sv - shared encodings for the CODE-port scratchpad controller
package code_axi_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam int BEAT_W = 4;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE    = 2'd0;
  localparam state_t ST_WR_DATA = 2'd1;
  localparam state_t ST_WR_RESP = 2'd2;
  localparam state_t ST_RD_RUN  = 2'd3;

endpackage

// File: rtl/scratch_rd_skid.sv
// rtl/scratch_rd_skid.sv - two-entry read-return buffer with same-cycle bypass
module scratch_rd_skid (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [31:0] in_data,
  input  logic [1:0]  in_resp,
  input  logic        in_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [1:0]  out_resp,
  output logic        out_last,
  output logic [1:0]  count
);

  logic [34:0] slot0, slot1, in_word, head;
  logic        wptr, rptr, bypass, push, pop;

  assign in_word   = {in_last, in_resp, in_data};
  assign head      = rptr ? slot1 : slot0;
  // Returning SRAM data goes straight out when nothing older is buffered.
  assign bypass    = (count == 2'd0) && in_valid;
  assign push      = in_valid && !(bypass && out_ready);
  assign pop       = (count != 2'd0) && out_ready;
  assign out_valid = (count != 2'd0) || in_valid;
  assign {out_last, out_resp, out_data} = bypass ? in_word : head;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot0 <= '0;
      slot1 <= '0;
      wptr  <= 1'b0;
      rptr  <= 1'b0;
      count <= 2'd0;
    end else begin
      if (push) begin
        if (wptr) slot1 <= in_word;
        else      slot0 <= in_word;
        wptr <= !wptr;
      end
      if (pop) rptr <= !rptr;
      if (push && !pop)      count <= count + 2'd1;
      else if (pop && !push) count <= count - 2'd1;
    end
  end

endmodule

// File: rtl/code_axi_scratch_ctrl.sv
// rtl/code_axi_scratch_ctrl.sv - AXI3 CODE-port slave sequencing bursts into the scratchpad SRAM
// Optional saturating beat/error counters are built when CODE_AXI_PERF_CNT_EN is defined.
module code_axi_scratch_ctrl
  import code_axi_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE = 32'h1000_0000,
  parameter int          MEM_AW    = 12
) (
  input  logic              sys_clock,
  input  logic              reset,
`ifdef CODE_AXI_PERF_CNT_EN
  input  logic              perf_clr,
  output logic [31:0]       perf_rd_beats,
  output logic [31:0]       perf_wr_beats,
  output logic [15:0]       perf_err,
`endif
  input  logic [31:0]       s_awaddr,
  input  logic [3:0]        s_awlen,
  input  logic [2:0]        s_awsize,
  input  logic [1:0]        s_awburst,
  input  logic              s_awvalid,
  output logic              s_awready,
  input  logic [31:0]       s_wdata,
  input  logic [3:0]        s_wstrb,
  input  logic              s_wlast,
  input  logic              s_wvalid,
  output logic              s_wready,
  output logic [1:0]        s_bresp,
  output logic              s_bvalid,
  input  logic              s_bready,
  input  logic [31:0]       s_araddr,
  input  logic [3:0]        s_arlen,
  input  logic [2:0]        s_arsize,
  input  logic [1:0]        s_arburst,
  input  logic              s_arvalid,
  output logic              s_arready,
  output logic [31:0]       s_rdata,
  output logic [1:0]        s_rresp,
  output logic              s_rlast,
  output logic              s_rvalid,
  input  logic              s_rready,
  output logic              mem_en,
  output logic [3:0]        mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  state_t            state;
  logic              prio_rd, err_q, wlast_bad, inflight, inflight_last;
  logic [MEM_AW-1:0] cur_addr;
  logic [BEAT_W-1:0] len_q, wcnt;
  logic [1:0]        burst_q;
  logic [BEAT_W:0]   rd_issued;
  logic [1:0]        rd_count;

  logic        gnt_rd, gnt_wr, a_err, w_hs, w_final, rd_issue, r_done;
  logic [31:0] a_addr;
  logic [3:0]  a_len;
  logic [2:0]  a_size;
  logic [1:0]  a_burst;

  assign gnt_rd  = (state == ST_IDLE) && s_arvalid && (!s_awvalid || prio_rd);
  assign gnt_wr  = (state == ST_IDLE) && s_awvalid && !gnt_rd;
  assign a_addr  = gnt_rd ? s_araddr  : s_awaddr;
  assign a_len   = gnt_rd ? s_arlen   : s_awlen;
  assign a_size  = gnt_rd ? s_arsize  : s_awsize;
  assign a_burst = gnt_rd ? s_arburst : s_awburst;

  // Last INCR beat must stay inside the window: word offset + len must not carry out.
  assign a_err = (a_addr[31:MEM_AW+2] != ADDR_BASE[31:MEM_AW+2]) || (a_size != 3'b010) ||
                 a_burst[1] || (a_addr[1:0] != 2'b00) ||
                 ((a_burst == BURST_INCR) &&
                  (({1'b0, a_addr[MEM_AW+1:2]} + {{(MEM_AW+1-BEAT_W){1'b0}}, a_len}) >
                   {1'b0, {MEM_AW{1'b1}}}));

  assign s_awready = gnt_wr;
  assign s_arready = gnt_rd;
  assign s_wready  = (state == ST_WR_DATA);
  assign s_bvalid  = (state == ST_WR_RESP);
  assign s_bresp   = (s_bvalid && (err_q || wlast_bad)) ? RESP_SLVERR : RESP_OKAY;

  assign w_hs     = (state == ST_WR_DATA) && s_wvalid;
  assign w_final  = (wcnt == len_q);
  // At most two beats may be buffered or returning, so backpressure never drops data.
  assign rd_issue = (state == ST_RD_RUN) && (rd_issued <= {1'b0, len_q}) &&
                    (({1'b0, rd_count} + {2'b00, inflight}) < 3'd2);
  assign r_done   = s_rvalid && s_rready && s_rlast;

  assign mem_en    = (w_hs || rd_issue) && !err_q;
  assign mem_we    = (w_hs && !err_q) ? s_wstrb : 4'b0000;
  assign mem_addr  = cur_addr;
  assign mem_wdata = s_wdata;

  scratch_rd_skid u_skid (
    .clk       (sys_clock),
    .rst_n     (reset),
    .in_valid  (inflight),
    .in_data   (err_q ? 32'd0 : mem_rdata),
    .in_resp   (err_q ? RESP_SLVERR : RESP_OKAY),
    .in_last   (inflight_last),
    .out_valid (s_rvalid),
    .out_ready (s_rready),
    .out_data  (s_rdata),
    .out_resp  (s_rresp),
    .out_last  (s_rlast),
    .count     (rd_count)
  );

  always_ff @(posedge sys_clock or negedge reset) begin
    if (!reset) begin
      state         <= ST_IDLE;
      prio_rd       <= 1'b1;
      err_q         <= 1'b0;
      wlast_bad     <= 1'b0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      cur_addr      <= '0;
      len_q         <= '0;
      wcnt          <= '0;
      burst_q       <= BURST_FIXED;
      rd_issued     <= '0;
    end else begin
      inflight <= rd_issue;
      if (rd_issue) inflight_last <= (rd_issued[BEAT_W-1:0] == len_q);
      case (state)
        ST_IDLE: if (gnt_rd || gnt_wr) begin
          cur_addr  <= a_addr[MEM_AW+1:2];
          len_q     <= a_len;
          burst_q   <= a_burst;
          err_q     <= a_err;
          wcnt      <= '0;
          rd_issued <= '0;
          wlast_bad <= 1'b0;
          if (s_arvalid && s_awvalid) prio_rd <= !prio_rd;
          state <= gnt_rd ? ST_RD_RUN : ST_WR_DATA;
        end
        ST_WR_DATA: if (w_hs) begin
          wcnt <= wcnt + BEAT_W'(1);
          if (s_wlast != w_final) wlast_bad <= 1'b1;
          if (burst_q == BURST_INCR) cur_addr <= cur_addr + MEM_AW'(1);
          if (w_final) state <= ST_WR_RESP;
        end
        ST_WR_RESP: if (s_bready) state <= ST_IDLE;
        ST_RD_RUN: begin
          if (rd_issue) begin
            rd_issued <= rd_issued + (BEAT_W+1)'(1);
            if (burst_q == BURST_INCR) cur_addr <= cur_addr + MEM_AW'(1);
          end
          if (r_done) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef CODE_AXI_PERF_CNT_EN
  logic [31:0] wr_beats_n;
  assign wr_beats_n = {{(32-BEAT_W){1'b0}}, len_q} + 32'd1;

  always_ff @(posedge sys_clock or negedge reset) begin
    if (!reset) begin
      perf_rd_beats <= '0;
      perf_wr_beats <= '0;
      perf_err      <= '0;
    end else if (perf_clr) begin
      perf_rd_beats <= '0;
      perf_wr_beats <= '0;
      perf_err      <= '0;
    end else begin
      if (s_rvalid && s_rready && (s_rresp == RESP_OKAY) && (perf_rd_beats != '1))
        perf_rd_beats <= perf_rd_beats + 32'd1;
      if (s_bvalid && s_bready && (s_bresp == RESP_OKAY))
        perf_wr_beats <= (perf_wr_beats > (32'hFFFF_FFFF - wr_beats_n)) ? '1 : perf_wr_beats + wr_beats_n;
      if (((s_bvalid && s_bready && (s_bresp == RESP_SLVERR)) ||
           (r_done && (s_rresp == RESP_SLVERR))) && (perf_err != '1))
        perf_err <= perf_err + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_code_axi_scratch_ctrl.sv
// tb/tb_code_axi_scratch_ctrl.sv - scoreboard bench for the CODE-port scratchpad controller
module tb_code_axi_scratch_ctrl;
  import code_axi_pkg::*;

  typedef struct packed {
    logic [31:0] d;
    logic [1:0]  r;
    logic        l;
  } rbeat_t;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic [31:0] s_awaddr = '0, s_wdata = '0, s_araddr = '0, s_rdata, mem_wdata, mem_rdata = '0;
  logic [3:0]  s_awlen = '0, s_wstrb = '0, s_arlen = '0, mem_we;
  logic [2:0]  s_awsize = 3'b010, s_arsize = 3'b010;
  logic [1:0]  s_awburst = '0, s_arburst = '0, s_bresp, s_rresp;
  logic        s_awvalid = 1'b0, s_wlast = 1'b0, s_wvalid = 1'b0, s_arvalid = 1'b0;
  logic        s_bready = 1'b1, s_rready = 1'b1;
  logic        s_awready, s_wready, s_bvalid, s_arready, s_rlast, s_rvalid, mem_en;
  logic [11:0] mem_addr;
`ifdef CODE_AXI_PERF_CNT_EN
  logic        perf_clr = 1'b0;
  logic [31:0] perf_rd_beats, perf_wr_beats;
  logic [15:0] perf_err;
`endif

  logic [31:0] sram [4096];
  rbeat_t      exp_r [$];
  logic [1:0]  exp_b [$];
  logic [47:0] exp_mw [$];
  logic        exp_g [$];
  int          checks = 0, errors = 0, r_hs_cnt = 0, mem_en_cnt = 0, base;
  bit          prev_stall = 0, hit;
  logic [34:0] prev_word = '0;

  code_axi_scratch_ctrl dut (
    .sys_clock (clk), .reset (rst_n),
`ifdef CODE_AXI_PERF_CNT_EN
    .perf_clr (perf_clr), .perf_rd_beats (perf_rd_beats), .perf_wr_beats (perf_wr_beats), .perf_err (perf_err),
`endif
    .s_awaddr (s_awaddr), .s_awlen (s_awlen), .s_awsize (s_awsize), .s_awburst (s_awburst),
    .s_awvalid (s_awvalid), .s_awready (s_awready),
    .s_wdata (s_wdata), .s_wstrb (s_wstrb), .s_wlast (s_wlast), .s_wvalid (s_wvalid), .s_wready (s_wready),
    .s_bresp (s_bresp), .s_bvalid (s_bvalid), .s_bready (s_bready),
    .s_araddr (s_araddr), .s_arlen (s_arlen), .s_arsize (s_arsize), .s_arburst (s_arburst),
    .s_arvalid (s_arvalid), .s_arready (s_arready),
    .s_rdata (s_rdata), .s_rresp (s_rresp), .s_rlast (s_rlast), .s_rvalid (s_rvalid), .s_rready (s_rready),
    .mem_en (mem_en), .mem_we (mem_we), .mem_addr (mem_addr), .mem_wdata (mem_wdata), .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  initial for (int i = 0; i < 4096; i++) sram[i] = '0;

  always @(posedge clk) begin
    if (mem_en) begin
      for (int b = 0; b < 4; b++) if (mem_we[b]) sram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
      if (mem_we == 4'd0) mem_rdata <= sram[mem_addr];
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic fail_unexp(input string nm);
    checks++;
    errors++;
    $display("FAIL %s unexpected (no entry queued)", nm);
  endtask

  // Monitor: pops expectations whenever the DUT completes a handshake or SRAM write.
  initial begin
    rbeat_t eb;
    forever begin
      @(negedge clk);
      if (!rst_n) prev_stall = 0;
      else begin
        if ((s_awvalid && s_awready) || (s_arvalid && s_arready)) begin
          if (exp_g.size() == 0) fail_unexp("grant");
          else chk("grant_is_read", {63'd0, s_arready}, {63'd0, exp_g.pop_front()});
        end
        if (prev_stall)
          chk("r_stable", {28'd0, s_rvalid, s_rdata, s_rresp, s_rlast}, {28'd0, 1'b1, prev_word});
        prev_stall = s_rvalid && !s_rready;
        prev_word  = {s_rdata, s_rresp, s_rlast};
        if (s_rvalid && s_rready) begin
          if (exp_r.size() == 0) fail_unexp("rbeat");
          else begin
            eb = exp_r.pop_front();
            chk("rbeat", {29'd0, s_rdata, s_rresp, s_rlast}, {29'd0, eb});
          end
          r_hs_cnt++;
        end
        if (s_bvalid && s_bready) begin
          if (exp_b.size() == 0) fail_unexp("bresp");
          else chk("bresp", {62'd0, s_bresp}, {62'd0, exp_b.pop_front()});
        end
        if (mem_en && (mem_we != 4'd0)) begin
          if (exp_mw.size() == 0) fail_unexp("memwr");
          else chk("memwr", {16'd0, mem_addr, mem_we, mem_wdata}, {16'd0, exp_mw.pop_front()});
        end
        if (mem_en) mem_en_cnt++;
      end
    end
  end

  task automatic hs_wait(input int ch, input string nm);
    bit got = 0;
    for (int i = 0; i < 400 && !got; i++) begin
      @(negedge clk);
      got = (ch == 0) ? s_awready : (ch == 1) ? s_arready : s_wready;
    end
    if (got) begin
      @(posedge clk);
      #1;
    end else begin
      checks++;
      errors++;
      $display("FAIL %s handshake timeout", nm);
    end
  endtask

  task automatic send_aw(input logic [31:0] a, input logic [3:0] l, input logic [1:0] b);
    s_awaddr = a; s_awlen = l; s_awburst = b; s_awvalid = 1'b1;
    hs_wait(0, "aw");
    s_awvalid = 1'b0;
  endtask

  task automatic send_ar(input logic [31:0] a, input logic [3:0] l, input logic [1:0] b);
    s_araddr = a; s_arlen = l; s_arburst = b; s_arvalid = 1'b1;
    hs_wait(1, "ar");
    s_arvalid = 1'b0;
  endtask

  task automatic wr_burst(input logic [31:0] a, input logic [3:0] l, input logic [1:0] b,
                          input logic [31:0] d0, input logic [3:0] st, input int last_at);
    send_aw(a, l, b);
    for (int i = 0; i <= int'(l); i++) begin
      s_wdata = d0 + 32'(i); s_wstrb = st; s_wlast = (i == last_at); s_wvalid = 1'b1;
      hs_wait(2, "w");
      s_wvalid = 1'b0;
    end
  endtask

  task automatic exp_wr(input logic [11:0] w, input int n, input bit incr, input logic [31:0] d0, input logic [3:0] st);
    for (int i = 0; i < n; i++) exp_mw.push_back({w + (incr ? 12'(i) : 12'd0), st, d0 + 32'(i)});
  endtask

  task automatic exp_rd(input logic [31:0] d0, input logic [31:0] step, input int n, input logic [1:0] rs);
    rbeat_t e;
    for (int i = 0; i < n; i++) begin
      e.d = d0 + step * 32'(i); e.r = rs; e.l = (i == n - 1);
      exp_r.push_back(e);
    end
  endtask

  task automatic drain(input string nm);
    int n = 0;
    while ((exp_r.size() + exp_b.size() + exp_mw.size() + exp_g.size()) != 0 && n < 600) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (n >= 600) begin
      errors++;
      $display("FAIL %s drain left r=%0d b=%0d w=%0d g=%0d", nm, exp_r.size(), exp_b.size(), exp_mw.size(), exp_g.size());
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_awready", s_awready, 0); chk("rst_arready", s_arready, 0); chk("rst_wready", s_wready, 0);
    chk("rst_bvalid", s_bvalid, 0);   chk("rst_rvalid", s_rvalid, 0);   chk("rst_bresp", s_bresp, 0);
    chk("rst_rresp", s_rresp, 0);     chk("rst_rdata", s_rdata, 0);     chk("rst_rlast", s_rlast, 0);
    chk("rst_mem_en", mem_en, 0);     chk("rst_mem_we", mem_we, 0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // 1: INCR write of 1..4 to words 4..7, then readback with latency check
    exp_g.push_back(1'b0); exp_wr(12'h004, 4, 1, 32'd1, 4'hF); exp_b.push_back(RESP_OKAY);
    wr_burst(32'h1000_0010, 4'd3, BURST_INCR, 32'd1, 4'hF, 3);
    drain("t1_wr");
    exp_g.push_back(1'b1); exp_rd(32'd1, 32'd1, 4, RESP_OKAY);
    send_ar(32'h1000_0010, 4'd3, BURST_INCR);
    @(negedge clk); chk("t1_mem_en_T1", mem_en, 1); chk("t1_rvalid_T1", s_rvalid, 0);
    @(negedge clk); chk("t1_rvalid_T2", s_rvalid, 1);
    drain("t1_rd");

    // 2: preload 16 words, read them back with rready toggling every cycle
    exp_g.push_back(1'b0); exp_wr(12'h040, 16, 1, 32'hA000_0000, 4'hF); exp_b.push_back(RESP_OKAY);
    wr_burst(32'h1000_0100, 4'd15, BURST_INCR, 32'hA000_0000, 4'hF, 15);
    drain("t2_wr");
    exp_g.push_back(1'b1); exp_rd(32'hA000_0000, 32'd1, 16, RESP_OKAY);
    s_rready = 1'b0;
    send_ar(32'h1000_0100, 4'd15, BURST_INCR);
    for (int i = 0; i < 300 && exp_r.size() != 0; i++) begin
      @(posedge clk); #1;
      s_rready = ~s_rready;
    end
    s_rready = 1'b1;
    drain("t2_rd");

    // 3: collisions - read wins first, then the pointer favours write
    exp_g.push_back(1'b1); exp_g.push_back(1'b0);
    exp_rd(32'd1, 32'd0, 1, RESP_OKAY); exp_wr(12'h080, 1, 1, 32'h55, 4'hF); exp_b.push_back(RESP_OKAY);
    fork
      send_ar(32'h1000_0010, 4'd0, BURST_INCR);
      wr_burst(32'h1000_0200, 4'd0, BURST_INCR, 32'h55, 4'hF, 0);
    join
    drain("t3_c1");
    exp_g.push_back(1'b0); exp_g.push_back(1'b1);
    exp_wr(12'h081, 1, 1, 32'h66, 4'hF); exp_b.push_back(RESP_OKAY); exp_rd(32'h55, 32'd0, 1, RESP_OKAY);
    fork
      send_ar(32'h1000_0200, 4'd0, BURST_INCR);
      wr_burst(32'h1000_0204, 4'd0, BURST_INCR, 32'h66, 4'hF, 0);
    join
    drain("t3_c2");

    // 4: out-of-window read, read past window end, WRAP write
    base = mem_en_cnt;
    exp_g.push_back(1'b1); exp_rd(32'd0, 32'd0, 2, RESP_SLVERR);
    send_ar(32'h2000_0000, 4'd1, BURST_INCR);
    drain("t4_rd_oow");
    exp_g.push_back(1'b1); exp_rd(32'd0, 32'd0, 2, RESP_SLVERR);
    send_ar(32'h1000_3FFC, 4'd1, BURST_INCR);
    drain("t4_rd_end");
    exp_g.push_back(1'b0); exp_b.push_back(RESP_SLVERR);
    wr_burst(32'h1000_0010, 4'd1, BURST_WRAP, 32'hDEAD, 4'hF, 1);
    drain("t4_wrap");
    chk("t4_no_mem_access", mem_en_cnt - base, 0);
    exp_g.push_back(1'b1); exp_rd(32'd1, 32'd0, 1, RESP_OKAY);
    send_ar(32'h1000_0010, 4'd0, BURST_INCR);
    drain("t4_unchanged");

    // 5: early wlast, byte strobes, FIXED burst
    exp_g.push_back(1'b0); exp_wr(12'h0C0, 3, 1, 32'd7, 4'hF); exp_b.push_back(RESP_SLVERR);
    wr_burst(32'h1000_0300, 4'd2, BURST_INCR, 32'd7, 4'hF, 1);
    drain("t5_wlast");
    exp_g.push_back(1'b0); exp_wr(12'h0D0, 1, 1, 32'hAABB_CCDD, 4'hF); exp_b.push_back(RESP_OKAY);
    wr_burst(32'h1000_0340, 4'd0, BURST_INCR, 32'hAABB_CCDD, 4'hF, 0);
    exp_g.push_back(1'b0); exp_wr(12'h0D0, 1, 1, 32'h1122_3344, 4'b0101); exp_b.push_back(RESP_OKAY);
    wr_burst(32'h1000_0340, 4'd0, BURST_INCR, 32'h1122_3344, 4'b0101, 0);
    exp_g.push_back(1'b1); exp_rd(32'hAA22_CC44, 32'd0, 1, RESP_OKAY);
    send_ar(32'h1000_0340, 4'd0, BURST_INCR);
    drain("t5_strb");
    exp_g.push_back(1'b0); exp_mw.push_back({12'h0E0, 4'hF, 32'h10}); exp_mw.push_back({12'h0E0, 4'hF, 32'h11});
    exp_b.push_back(RESP_OKAY);
    wr_burst(32'h1000_0380, 4'd1, BURST_FIXED, 32'h10, 4'hF, 1);
    exp_g.push_back(1'b1); exp_rd(32'h11, 32'd0, 2, RESP_OKAY);
    send_ar(32'h1000_0380, 4'd1, BURST_FIXED);
    drain("t5_fixed");

    // 6: reset in the middle of a 16-beat read, then a normal burst
    base = r_hs_cnt;
    exp_g.push_back(1'b1); exp_rd(32'hA000_0000, 32'd1, 16, RESP_OKAY);
    send_ar(32'h1000_0100, 4'd15, BURST_INCR);
    hit = 0;
    for (int i = 0; i < 200 && !hit; i++) begin
      @(posedge clk);
      hit = (r_hs_cnt >= base + 6);
    end
    chk("t6_reached_beat5", {63'd0, hit}, 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rvalid", s_rvalid, 0); chk("t6_rdata", s_rdata, 0); chk("t6_rresp", s_rresp, 0);
    chk("t6_rlast", s_rlast, 0);   chk("t6_mem_en", mem_en, 0); chk("t6_mem_we", mem_we, 0);
    chk("t6_bvalid", s_bvalid, 0); chk("t6_wready", s_wready, 0);
    exp_r.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    exp_g.push_back(1'b1); exp_rd(32'd1, 32'd1, 4, RESP_OKAY);
    send_ar(32'h1000_0010, 4'd3, BURST_INCR);
    drain("t6_after");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
